// File: rtl/vga_sync_decoder_if.sv
// vga_sync_decoder_if: VGA sync and colour lanes from the video source to the decoder.
interface vga_sync_decoder_if;
    logic       vga_h_sync;
    logic       vga_v_sync;
    logic [3:0] vga_R;
    logic [3:0] vga_G;
    logic [3:0] vga_B;
    modport master (output vga_h_sync, vga_v_sync, vga_R, vga_G, vga_B);
    modport slave  (input  vga_h_sync, vga_v_sync, vga_R, vga_G, vga_B);
endinterface

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: VGA receive checker - sync timing lock, pixel coordinates, per-frame CRC-16-CCITT.
// Define VGA_DECODER_STATS_EN to count non-black active pixels per frame into nonblack_cnt.
module vga_sync_decoder #(
    parameter int H_ACTIVE         = 640,
    parameter int H_FP             = 16,
    parameter int H_SYNC           = 96,
    parameter int H_BP             = 48,
    parameter int V_ACTIVE         = 480,
    parameter int V_FP             = 10,
    parameter int V_SYNC           = 2,
    parameter int V_BP             = 33,
    parameter int SYNC_ACTIVE_HIGH = 0
) (
    input  logic              CLK,
    input  logic              rst,
    vga_sync_decoder_if.slave bus,
    output logic [9:0]        pix_x,
    output logic [9:0]        pix_y,
    output logic              pix_valid,
    output logic              locked,
    output logic              frame_done,
    output logic [15:0]       frame_crc,
    output logic [7:0]        frame_cnt,
    output logic              err_hsync,
    output logic              err_vsync,
    output logic [18:0]       nonblack_cnt
);
    localparam int          H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int          V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_SW    = 11'(H_SYNC);
    localparam logic [10:0] H_LO    = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_HI    = 11'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0]  V_LO    = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  V_HI    = 10'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [10:0] V_TOT   = 11'(V_TOTAL);
    localparam logic        ACT     = (SYNC_ACTIVE_HIGH != 0);
    localparam logic [1:0]  S_SEARCH = 2'd0;
    localparam logic [1:0]  S_ALIGN  = 2'd1;
    localparam logic [1:0]  S_LOCKED = 2'd2;

    logic        r_hs_act, r_vs_act, r_hseen, r_vpend, r_align_err;
    logic [10:0] r_hcnt, r_lines;
    logic [9:0]  r_vcnt;
    logic [1:0]  r_state;
    logic [15:0] r_crc;
    logic        w_hs_act, w_vs_act, w_hs_edge, w_hs_fall, w_vs_edge;
    logic        w_active, w_valid, w_line_err, w_frame_err, w_done, w_is_locked;
    logic [10:0] w_hcnt;
    logic [9:0]  w_vcnt;
    logic [11:0] w_pix;
    logic [15:0] w_crc;

    assign w_hs_act    = (bus.vga_h_sync == ACT);
    assign w_vs_act    = (bus.vga_v_sync == ACT);
    assign w_hs_edge   = w_hs_act & ~r_hs_act;
    assign w_hs_fall   = ~w_hs_act & r_hs_act;
    assign w_vs_edge   = w_vs_act & ~r_vs_act;
    assign w_pix       = {bus.vga_R, bus.vga_G, bus.vga_B};
    assign w_hcnt      = w_hs_edge ? 11'd0 : r_hcnt + {10'd0, ~&r_hcnt};
    assign w_vcnt      = !w_hs_edge ? r_vcnt : (w_vs_edge | r_vpend) ? 10'd0 : r_vcnt + {9'd0, ~&r_vcnt};
    assign w_active    = (w_hcnt >= H_LO) && (w_hcnt < H_HI) && (w_vcnt >= V_LO) && (w_vcnt < V_HI);
    assign w_is_locked = (r_state == S_LOCKED);
    assign w_valid     = w_active & w_is_locked;
    // The first hsync edge after reset has no previous line to measure, so checks wait for it.
    assign w_line_err  = r_hseen & ((w_hs_edge & (r_hcnt != H_LAST)) | (w_hs_fall & (w_hcnt != H_SW)));
    assign w_frame_err = w_vs_edge & (r_lines != V_TOT);
    assign w_done      = w_is_locked & w_vs_edge & ~w_frame_err & ~w_line_err;

    // CRC-16-CCITT step over the 12-bit {R,G,B} word, MSB first.
    always_comb begin
        w_crc = r_crc;
        for (int i = 11; i >= 0; i--)
            w_crc = {w_crc[14:0], 1'b0} ^ ((w_crc[15] ^ w_pix[i]) ? 16'h1021 : 16'h0000);
    end

    // Sync history, position counters, line counting and running CRC.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_hs_act <= 1'b0;
            r_vs_act <= 1'b0;
            r_hseen  <= 1'b0;
            r_vpend  <= 1'b0;
            r_hcnt   <= 11'd0;
            r_vcnt   <= 10'd0;
            r_lines  <= 11'd0;
            r_crc    <= 16'hFFFF;
        end else begin
            r_hs_act <= w_hs_act;
            r_vs_act <= w_vs_act;
            r_hseen  <= r_hseen | w_hs_edge;
            r_vpend  <= w_hs_edge ? 1'b0 : (r_vpend | w_vs_edge);
            r_hcnt   <= w_hcnt;
            r_vcnt   <= w_vcnt;
            r_lines  <= w_vs_edge ? {10'd0, w_hs_edge} : r_lines + {10'd0, w_hs_edge & ~&r_lines};
            r_crc    <= w_vs_edge ? 16'hFFFF : w_active ? w_crc : r_crc;
        end
    end

    // Lock FSM: vsync starts alignment, one clean frame locks, any error while locked drops back.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_state     <= S_SEARCH;
            r_align_err <= 1'b0;
        end else begin
            r_align_err <= (r_state == S_ALIGN) & ~w_vs_edge & (r_align_err | w_line_err);
            if (r_state == S_SEARCH)
                r_state <= w_vs_edge ? S_ALIGN : S_SEARCH;
            else if (r_state == S_ALIGN)
                r_state <= (w_vs_edge & ~w_frame_err & ~w_line_err & ~r_align_err) ? S_LOCKED : S_ALIGN;
            else if (w_is_locked)
                r_state <= (w_line_err | w_frame_err) ? S_SEARCH : S_LOCKED;
            else
                r_state <= S_SEARCH;
        end
    end

    // Registered pixel outputs, sticky errors and per-frame results.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            pix_valid  <= 1'b0;
            pix_x      <= 10'd0;
            pix_y      <= 10'd0;
            locked     <= 1'b0;
            frame_done <= 1'b0;
            frame_crc  <= 16'd0;
            frame_cnt  <= 8'd0;
            err_hsync  <= 1'b0;
            err_vsync  <= 1'b0;
        end else begin
            pix_valid  <= w_valid;
            pix_x      <= w_valid ? 10'(w_hcnt - H_LO) : 10'd0;
            pix_y      <= w_valid ? (w_vcnt - V_LO) : 10'd0;
            locked     <= (r_state == S_ALIGN) ? (w_vs_edge & ~w_frame_err & ~w_line_err & ~r_align_err)
                                               : (w_is_locked & ~w_line_err & ~w_frame_err);
            frame_done <= w_done;
            frame_crc  <= w_done ? r_crc : frame_crc;
            frame_cnt  <= frame_cnt + {7'd0, w_done};
            err_hsync  <= err_hsync | (w_is_locked & w_line_err);
            err_vsync  <= err_vsync | (w_is_locked & w_frame_err);
        end
    end

`ifdef VGA_DECODER_STATS_EN
    logic [18:0] r_nb;

    // Non-black active pixel count, latched alongside the frame CRC.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_nb         <= 19'd0;
            nonblack_cnt <= 19'd0;
        end else begin
            r_nb         <= w_vs_edge ? 19'd0 : r_nb + {18'd0, w_active & (|w_pix)};
            nonblack_cnt <= w_done ? r_nb : nonblack_cnt;
        end
    end
`else
    assign nonblack_cnt = 19'd0;
`endif
endmodule
